// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a held output slot
// for decode, MIPS-style delayed branches and flush/ERET redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ireq_valid;
  logic [31:0] r_pc_req;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic        r_kill;
  logic [31:0] r_kill_pc;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;

  logic [31:0] w_branch_tgt;
  logic [31:0] w_flush_pc;
  logic        w_deliver;
  logic [31:0] w_next_pc;
  logic        w_unused_bits;

  assign w_branch_tgt  = {branch_target[31:2], 2'b00};
  assign w_flush_pc    = {flush_pc[31:2], 2'b00};
  assign w_deliver     = (r_state == S_OUT) && !stall;
  assign w_unused_bits = ^{branch_target[1:0], flush_pc[1:0]};

  // A same-cycle branch makes the delivered word its delay slot, so it wins over pend.
  always_comb begin
    w_next_pc = r_out_pc + 32'd4;
    if (branch_taken)
      w_next_pc = w_branch_tgt;
    else if (r_pend)
      w_next_pc = r_pend_tgt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_REQ;
      r_ireq_valid <= 1'b1;
      r_pc_req     <= RESET_PC;
      r_pend       <= 1'b0;
      r_pend_tgt   <= 32'd0;
      r_kill       <= 1'b0;
      r_kill_pc    <= 32'd0;
      r_out_valid  <= 1'b0;
      r_out_pc     <= 32'd0;
      r_out_instr  <= 32'd0;
    end else if (flush) begin
      r_pend <= 1'b0;
      case (r_state)
        // The in-flight address must stay on the bus; the redirect waits in r_kill_pc.
        S_REQ: begin
          r_kill    <= 1'b1;
          r_kill_pc <= w_flush_pc;
          if (ireq_ready) begin
            r_state      <= S_WAIT;
            r_ireq_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            r_kill       <= 1'b0;
            r_pc_req     <= w_flush_pc;
            r_state      <= S_REQ;
            r_ireq_valid <= 1'b1;
          end else begin
            r_kill    <= 1'b1;
            r_kill_pc <= w_flush_pc;
          end
        end
        S_OUT: begin
          r_out_valid  <= 1'b0;
          r_pc_req     <= w_flush_pc;
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
        default: begin
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
      endcase
    end else begin
      if (branch_taken && !w_deliver) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= w_branch_tgt;
      end
      case (r_state)
        S_REQ: begin
          if (ireq_ready) begin
            r_state      <= S_WAIT;
            r_ireq_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            if (r_kill) begin
              r_kill       <= 1'b0;
              r_pc_req     <= r_kill_pc;
              r_state      <= S_REQ;
              r_ireq_valid <= 1'b1;
            end else begin
              r_out_pc    <= r_pc_req;
              r_out_instr <= iresp_data;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (!stall) begin
            r_out_valid  <= 1'b0;
            r_pc_req     <= w_next_pc;
            r_pend       <= 1'b0;
            r_state      <= S_REQ;
            r_ireq_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
      endcase
    end
  end

  assign ireq_valid = r_ireq_valid;
  assign ireq_addr  = r_pc_req;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;

endmodule
